// File: rtl/ram_initiator_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pkg_ram: RAM op protocol types plus shared alignment/extension helpers.
// Revision: 1.0
// ----------------------------------------------------------------------------
package pkg_ram;

  localparam int RAM_ADDRW     = 17;
  localparam int RAM_LONG_SIZE = 32;

  typedef enum logic [1:0] {
    RAM_NOP   = 2'd0,
    RAM_FETCH = 2'd1,
    RAM_STORE = 2'd2
  } op_t;

  typedef enum logic [1:0] {
    RAM_BYTE = 2'd0,
    RAM_WORD = 2'd1,
    RAM_LONG = 2'd2
  } data_type_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } ram_init_state_t;

  // Right-justified data narrowed to the access size, then sign- or zero-extended.
  function automatic logic [RAM_LONG_SIZE-1:0] ram_extend(
    input logic [RAM_LONG_SIZE-1:0] data,
    input data_type_t               typ,
    input logic                     sgn
  );
    logic [RAM_LONG_SIZE-1:0] res;
    res = data;
    case (typ)
      RAM_BYTE: res = {{(RAM_LONG_SIZE-8){sgn & data[7]}}, data[7:0]};
      RAM_WORD: res = {{(RAM_LONG_SIZE-16){sgn & data[15]}}, data[15:0]};
      default:  res = data;
    endcase
    return res;
  endfunction

  // Only the two low address bits decide alignment.
  function automatic logic ram_aligned(
    input logic [1:0] addr,
    input data_type_t typ
  );
    logic ok;
    ok = 1'b1;
    case (typ)
      RAM_WORD: ok = ~addr[0];
      RAM_LONG: ok = (addr == 2'b00);
      default:  ok = 1'b1;
    endcase
    return ok;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ram_initiator_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ram_initiator_if: request/response bus plus RAM op port of the initiator.
// Revision: 1.0
// ----------------------------------------------------------------------------
interface ram_initiator_if #(
  parameter int DATA_W = pkg_ram::RAM_LONG_SIZE
);

  logic                         req_valid;
  logic                         req_ready;
  pkg_ram::op_t                 req_op;
  pkg_ram::data_type_t          req_type;
  logic                         req_signed;
  logic [pkg_ram::RAM_ADDRW-1:0] req_addr;
  logic [DATA_W-1:0]            req_wdata;

  logic                         rsp_valid;
  logic [DATA_W-1:0]            rsp_rdata;
  logic                         rsp_err;

  pkg_ram::op_t                 ram_op;
  pkg_ram::data_type_t          ram_type;
  logic [pkg_ram::RAM_ADDRW-1:0] ram_addr;
  logic [DATA_W-1:0]            ram_wdata;
  logic [DATA_W-1:0]            ram_rdata;

  // Environment side: the load/store unit and the RAM responder.
  modport master (
    output req_valid, req_op, req_type, req_signed, req_addr, req_wdata, ram_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  ram_op, ram_type, ram_addr, ram_wdata
  );

  // The initiator itself.
  modport slave (
    input  req_valid, req_op, req_type, req_signed, req_addr, req_wdata, ram_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output ram_op, ram_type, ram_addr, ram_wdata
  );

endinterface
`default_nettype wire

// File: rtl/ram_initiator.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ram_initiator: one load/store request -> one RAM_FETCH/RAM_STORE -> one response.
// Revision: 1.0
// ----------------------------------------------------------------------------
module ram_initiator
  import pkg_ram::*;
#(
  parameter int FETCH_LAT = 1,
  parameter int DATA_W    = RAM_LONG_SIZE
) (
  input logic            clk,
  input logic            rst,
  ram_initiator_if.slave bus
);

  localparam int                c_cnt_w    = (FETCH_LAT > 1) ? $clog2(FETCH_LAT) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_load = c_cnt_w'(FETCH_LAT - 1);

  ram_init_state_t       r_state;
  ram_init_state_t       w_state_nxt;
  logic [c_cnt_w-1:0]    r_cnt;
  logic [c_cnt_w-1:0]    w_cnt_nxt;
  logic                  r_signed;

  op_t                   r_ram_op;
  data_type_t            r_ram_type;
  logic [RAM_ADDRW-1:0]  r_ram_addr;
  logic [DATA_W-1:0]     r_ram_wdata;
  logic [DATA_W-1:0]     r_rsp_rdata;
  logic                  r_rsp_err;

  logic                  w_issue_load;
  logic                  w_rsp_load;
  logic                  w_rsp_err_nxt;
  logic [DATA_W-1:0]     w_rsp_rdata_nxt;
  logic                  w_aligned;
  logic                  w_access;

  assign w_aligned = ram_aligned(bus.req_addr[1:0], bus.req_type);
  assign w_access  = (bus.req_op == RAM_FETCH) || (bus.req_op == RAM_STORE);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_issue_load    = 1'b0;
    w_rsp_load      = 1'b0;
    w_rsp_err_nxt   = 1'b0;
    w_rsp_rdata_nxt = '0;
    case (r_state)
      IDLE: begin
        if (bus.req_valid) begin
          if (!w_access) begin
            w_state_nxt = RESP;
            w_rsp_load  = 1'b1;
          end else if (!w_aligned) begin
            // Misaligned accesses never reach the RAM.
            w_state_nxt   = RESP;
            w_rsp_load    = 1'b1;
            w_rsp_err_nxt = 1'b1;
          end else begin
            w_state_nxt  = ISSUE;
            w_issue_load = 1'b1;
          end
        end
      end
      ISSUE: begin
        if (r_ram_op == RAM_FETCH) begin
          w_state_nxt = WAIT;
          w_cnt_nxt   = c_cnt_load;
        end else begin
          w_state_nxt = RESP;
          w_rsp_load  = 1'b1;
        end
      end
      WAIT: begin
        if (r_cnt == '0) begin
          w_state_nxt     = RESP;
          w_rsp_load      = 1'b1;
          w_rsp_rdata_nxt = DATA_W'(ram_extend(RAM_LONG_SIZE'(bus.ram_rdata), r_ram_type, r_signed));
        end else begin
          w_cnt_nxt = r_cnt - c_cnt_w'(1);
        end
      end
      RESP: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // RAM-side fields only change when an access is actually issued.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_signed    <= 1'b0;
      r_ram_op    <= RAM_NOP;
      r_ram_type  <= RAM_BYTE;
      r_ram_addr  <= '0;
      r_ram_wdata <= '0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_ram_op <= w_issue_load ? bus.req_op : RAM_NOP;
      if (w_issue_load) begin
        r_signed    <= bus.req_signed;
        r_ram_type  <= bus.req_type;
        r_ram_addr  <= bus.req_addr;
        r_ram_wdata <= DATA_W'(ram_extend(RAM_LONG_SIZE'(bus.req_wdata), bus.req_type, 1'b0));
      end
      if (w_rsp_load) begin
        r_rsp_rdata <= w_rsp_rdata_nxt;
        r_rsp_err   <= w_rsp_err_nxt;
      end
    end
  end

  assign bus.req_ready = (r_state == IDLE);
  assign bus.rsp_valid = (r_state == RESP);
  assign bus.rsp_rdata = r_rsp_rdata;
  assign bus.rsp_err   = r_rsp_err;
  assign bus.ram_op    = r_ram_op;
  assign bus.ram_type  = r_ram_type;
  assign bus.ram_addr  = r_ram_addr;
  assign bus.ram_wdata = r_ram_wdata;

endmodule
`default_nettype wire

// File: tb/tb_ram_initiator.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_ram_initiator: directed checks on three initiators with FETCH_LAT 1, 2, 3.
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_ram_initiator;
  import pkg_ram::*;

  logic        clk;
  logic        rst;
  int          sel;
  logic        req_valid;
  op_t         req_op;
  data_type_t  req_type;
  logic        req_signed;
  logic [16:0] req_addr;
  logic [31:0] req_wdata;
  logic [31:0] ram_rdata;
  logic [31:0] fetch_data;
  int          cd;

  logic        obs_ready, obs_rsp_valid, obs_err;
  logic [31:0] obs_rdata, obs_wdata;
  op_t         obs_ram_op;
  data_type_t  obs_ram_type;
  logic [16:0] obs_ram_addr;

  int n_checks, n_pass;
  int n_store, n_fetch, n_rsp;

  ram_initiator_if #(.DATA_W(32)) bus1 ();
  ram_initiator_if #(.DATA_W(32)) bus2 ();
  ram_initiator_if #(.DATA_W(32)) bus3 ();

  ram_initiator #(.FETCH_LAT(1), .DATA_W(32)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));
  ram_initiator #(.FETCH_LAT(2), .DATA_W(32)) u_dut2 (.clk(clk), .rst(rst), .bus(bus2.slave));
  ram_initiator #(.FETCH_LAT(3), .DATA_W(32)) u_dut3 (.clk(clk), .rst(rst), .bus(bus3.slave));

  assign bus1.req_valid = req_valid && (sel == 1);
  assign bus2.req_valid = req_valid && (sel == 2);
  assign bus3.req_valid = req_valid && (sel == 3);
  assign bus1.req_op = req_op;      assign bus2.req_op = req_op;      assign bus3.req_op = req_op;
  assign bus1.req_type = req_type;  assign bus2.req_type = req_type;  assign bus3.req_type = req_type;
  assign bus1.req_signed = req_signed; assign bus2.req_signed = req_signed; assign bus3.req_signed = req_signed;
  assign bus1.req_addr = req_addr;  assign bus2.req_addr = req_addr;  assign bus3.req_addr = req_addr;
  assign bus1.req_wdata = req_wdata; assign bus2.req_wdata = req_wdata; assign bus3.req_wdata = req_wdata;
  assign bus1.ram_rdata = ram_rdata; assign bus2.ram_rdata = ram_rdata; assign bus3.ram_rdata = ram_rdata;

  always_comb begin
    case (sel)
      2: begin
        obs_ready = bus2.req_ready; obs_rsp_valid = bus2.rsp_valid; obs_err = bus2.rsp_err;
        obs_rdata = bus2.rsp_rdata; obs_wdata = bus2.ram_wdata; obs_ram_op = bus2.ram_op;
        obs_ram_type = bus2.ram_type; obs_ram_addr = bus2.ram_addr;
      end
      3: begin
        obs_ready = bus3.req_ready; obs_rsp_valid = bus3.rsp_valid; obs_err = bus3.rsp_err;
        obs_rdata = bus3.rsp_rdata; obs_wdata = bus3.ram_wdata; obs_ram_op = bus3.ram_op;
        obs_ram_type = bus3.ram_type; obs_ram_addr = bus3.ram_addr;
      end
      default: begin
        obs_ready = bus1.req_ready; obs_rsp_valid = bus1.rsp_valid; obs_err = bus1.rsp_err;
        obs_rdata = bus1.rsp_rdata; obs_wdata = bus1.ram_wdata; obs_ram_op = bus1.ram_op;
        obs_ram_type = bus1.ram_type; obs_ram_addr = bus1.ram_addr;
      end
    endcase
  end

  // RAM model: fetched data is valid only in the cycle FETCH_LAT edges after the fetch is seen.
  always @(posedge clk) begin
    if (obs_ram_op == RAM_FETCH) cd <= sel;
    else if (cd != 0)            cd <= cd - 1;
  end
  assign ram_rdata = (cd == 1) ? fetch_data : 32'h5A5A5A5A;

  always @(negedge clk) begin
    if (obs_ram_op == RAM_STORE) n_store++;
    if (obs_ram_op == RAM_FETCH) n_fetch++;
    if (obs_rsp_valid)           n_rsp++;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, act, exp);
  endtask

  // Presents a request at a negedge and leaves after the accept edge.
  task automatic send(input int s, input op_t op, input data_type_t ty, input logic sg,
                      input logic [16:0] a, input logic [31:0] wd);
    @(negedge clk);
    sel = s; req_op = op; req_type = ty; req_signed = sg; req_addr = a; req_wdata = wd;
    req_valid = 1'b1;
    #1 check("ready_before_accept", obs_ready, 1'b1);
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string tag, input int exp_cyc);
    int c;
    c = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (obs_rsp_valid) begin
        c = k;
        break;
      end
    end
    check(tag, c, exp_cyc);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int s0, f0, r0, n_acc;
    int acc_at [3];
    n_checks = 0; n_pass = 0; n_store = 0; n_fetch = 0; n_rsp = 0; cd = 0;
    rst = 1'b1; sel = 1; req_valid = 1'b0; req_op = RAM_NOP; req_type = RAM_BYTE;
    req_signed = 1'b0; req_addr = '0; req_wdata = '0; fetch_data = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", obs_ready, 1'b1);
    check("rst_rsp_valid", obs_rsp_valid, 1'b0);
    check("rst_rdata", obs_rdata, 32'h0);
    check("rst_err", obs_err, 1'b0);
    check("rst_ram_op", obs_ram_op, RAM_NOP);
    check("rst_ram_type", obs_ram_type, RAM_BYTE);
    check("rst_ram_addr", obs_ram_addr, 17'h0);
    check("rst_ram_wdata", obs_wdata, 32'h0);
    rst = 1'b0;

    // Aligned long store
    send(1, RAM_STORE, RAM_LONG, 1'b0, 17'h00104, 32'hDEADBEEF);
    @(negedge clk);
    check("st_long_op", obs_ram_op, RAM_STORE);
    check("st_long_addr", obs_ram_addr, 17'h00104);
    check("st_long_wdata", obs_wdata, 32'hDEADBEEF);
    check("st_long_type", obs_ram_type, RAM_LONG);
    check("st_long_busy", obs_ready, 1'b0);
    @(negedge clk);
    check("st_long_rsp", obs_rsp_valid, 1'b1);
    check("st_long_err", obs_err, 1'b0);
    check("st_long_rdata", obs_rdata, 32'h0);
    @(negedge clk);
    check("st_long_rsp_pulse", obs_rsp_valid, 1'b0);
    check("st_long_op_after", obs_ram_op, RAM_NOP);
    check("st_long_addr_hold", obs_ram_addr, 17'h00104);

    // Byte store masks upper data bits
    send(1, RAM_STORE, RAM_BYTE, 1'b0, 17'h00010, 32'h123456A5);
    @(negedge clk);
    check("st_byte_wdata", obs_wdata, 32'h000000A5);
    check("st_byte_type", obs_ram_type, RAM_BYTE);
    wait_rsp("st_byte_lat", 1);

    // Byte fetches, FETCH_LAT=1
    fetch_data = 32'h00000080;
    send(1, RAM_FETCH, RAM_BYTE, 1'b1, 17'h00003, 32'h0);
    @(negedge clk);
    check("fb_op", obs_ram_op, RAM_FETCH);
    check("fb_addr", obs_ram_addr, 17'h00003);
    wait_rsp("fb_signed_lat", 2);
    check("fb_signed_rdata", obs_rdata, 32'hFFFFFF80);
    check("fb_signed_err", obs_err, 1'b0);
    send(1, RAM_FETCH, RAM_BYTE, 1'b0, 17'h00003, 32'h0);
    wait_rsp("fb_unsigned_lat", 3);
    check("fb_unsigned_rdata", obs_rdata, 32'h00000080);

    // Word and long fetches, FETCH_LAT=2
    fetch_data = 32'h0000ABCD;
    send(2, RAM_FETCH, RAM_WORD, 1'b1, 17'h00002, 32'h0);
    wait_rsp("fw_lat2", 4);
    check("fw_rdata", obs_rdata, 32'hFFFFABCD);
    fetch_data = 32'h89ABCDEF;
    send(2, RAM_FETCH, RAM_LONG, 1'b1, 17'h00008, 32'h0);
    wait_rsp("fl_lat2", 4);
    check("fl_rdata", obs_rdata, 32'h89ABCDEF);

    // Misaligned and NOP requests never touch the RAM
    s0 = n_store; f0 = n_fetch;
    send(1, RAM_FETCH, RAM_WORD, 1'b0, 17'h00001, 32'h0);
    check("mis_word_op", obs_ram_op, RAM_NOP);
    @(negedge clk);
    check("mis_word_rsp", obs_rsp_valid, 1'b1);
    check("mis_word_err", obs_err, 1'b1);
    check("mis_word_rdata", obs_rdata, 32'h0);
    send(1, RAM_STORE, RAM_LONG, 1'b0, 17'h00006, 32'h11111111);
    wait_rsp("mis_long_lat", 1);
    check("mis_long_err", obs_err, 1'b1);
    check("mis_long_op", obs_ram_op, RAM_NOP);
    send(1, RAM_NOP, RAM_LONG, 1'b0, 17'h00003, 32'h0);
    wait_rsp("nop_lat", 1);
    check("nop_err", obs_err, 1'b0);
    @(negedge clk);
    check("mis_no_ram_ops", (n_store - s0) + (n_fetch - f0), 0);

    // Back-to-back stores with req_valid held high
    @(negedge clk);
    s0 = n_store; r0 = n_rsp; n_acc = 0;
    sel = 1; req_op = RAM_STORE; req_type = RAM_WORD; req_addr = 17'h00020;
    req_wdata = 32'hCAFE1234; req_valid = 1'b1;
    for (int k = 0; k < 12; k++) begin
      #1;
      if (obs_ready && n_acc < 3) begin
        acc_at[n_acc] = k;
        n_acc++;
      end
      @(posedge clk);
      if (n_acc == 3) begin
        #1 req_valid = 1'b0;
        break;
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("b2b_accepts", n_acc, 3);
    check("b2b_acc0", acc_at[0], 0);
    check("b2b_acc1", acc_at[1], 3);
    check("b2b_acc2", acc_at[2], 6);
    check("b2b_stores", n_store - s0, 3);
    check("b2b_rsps", n_rsp - r0, 3);

    // FETCH_LAT=3 fetch, then a reset during the next fetch's WAIT
    fetch_data = 32'hCAFEF00D;
    send(3, RAM_FETCH, RAM_LONG, 1'b0, 17'h00040, 32'h0);
    wait_rsp("fl_lat3", 5);
    check("fl_lat3_rdata", obs_rdata, 32'hCAFEF00D);
    fetch_data = 32'h76543210;
    send(3, RAM_FETCH, RAM_LONG, 1'b0, 17'h00044, 32'h0);
    @(negedge clk);
    @(negedge clk);
    r0 = n_rsp;
    rst = 1'b1;
    @(negedge clk);
    check("mrst_ram_op", obs_ram_op, RAM_NOP);
    check("mrst_ready", obs_ready, 1'b1);
    check("mrst_rsp_valid", obs_rsp_valid, 1'b0);
    check("mrst_rdata", obs_rdata, 32'h0);
    check("mrst_err", obs_err, 1'b0);
    check("mrst_ram_type", obs_ram_type, RAM_BYTE);
    check("mrst_ram_addr", obs_ram_addr, 17'h0);
    check("mrst_ram_wdata", obs_wdata, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    check("mrst_no_rsp", n_rsp - r0, 0);
    check("mrst_idle", obs_ready, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ram_initiator.md
Name: ram_initiator

Overview:
Initiator (client) side of the RAM op protocol: turns one CPU-style load/store request into a single RAM_FETCH or RAM_STORE on the RAM port. It waits out the fixed fetch latency, extends fetched data to 32 bits, and returns a one-cycle response. It sits between the core's load/store unit and the 4-block SPRAM RAM responder.

Parameters:
FETCH_LAT, 1, cycles from the edge sampling RAM_FETCH until ram_rdata is valid (>=1)
DATA_W, 32, response/write data width (RAM_LONG_SIZE)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  block can accept a request
req_op  in  op_t  RAM_NOP / RAM_FETCH / RAM_STORE
req_type  in  data_type_t  RAM_BYTE / RAM_WORD / RAM_LONG
req_signed  in  1  fetch only: 1 = sign-extend, 0 = zero-extend
req_addr  in  RAM_ADDRW (17)  byte address
req_wdata  in  DATA_W  store data, right-justified
rsp_valid  out  1  one-cycle completion pulse
rsp_rdata  out  DATA_W  extended fetch result
rsp_err  out  1  misaligned request, no RAM access made
ram_op  out  op_t  op to RAM, non-NOP for exactly one cycle per access
ram_type  out  data_type_t  access size to RAM
ram_addr  out  RAM_ADDRW  byte address to RAM
ram_wdata  out  DATA_W  store data to RAM, right-justified
ram_rdata  in  DATA_W  fetch data from RAM, right-justified

Behaviour:
- Clock and reset: single clock clk; rst is synchronous and active-high.
- Reset values: state IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, ram_op=RAM_NOP, ram_type=RAM_BYTE, ram_addr=0, ram_wdata=0.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- Handshake: a request is accepted on a clk edge with req_valid && req_ready. req_ready=1 only in IDLE (combinational from state). Request fields are registered at acceptance; inputs are don't-care afterwards.
- Alignment: RAM_WORD needs addr[0]=0; RAM_LONG needs addr[1:0]=0; RAM_BYTE is always aligned.
- IDLE transitions:
  - misaligned FETCH/STORE -> RESP with err=1, rdata=0, ram_op stays NOP.
  - RAM_NOP -> RESP with err=0, rdata=0.
  - otherwise -> ISSUE.
- ISSUE (one cycle): drives ram_op/ram_type/ram_addr from the registered request. ram_wdata carries req_wdata with bits above the access size forced to 0.
  - STORE -> RESP.
  - FETCH -> WAIT, with counter loaded to FETCH_LAT-1.
- WAIT: decrements the counter. When it reaches 0, ram_rdata is sampled that cycle: BYTE uses [7:0], WORD uses [15:0], LONG uses all bits. Extension is per req_signed. Then -> RESP.
  - FETCH_LAT=1: WAIT lasts exactly one cycle.
- RESP: rsp_valid=1 for exactly one cycle, then -> IDLE. There is no response backpressure.
  - rsp_rdata/rsp_err hold until the next RESP.
  - rsp_rdata=0 for stores.
- Outside ISSUE: ram_op=RAM_NOP. ram_addr/ram_type/ram_wdata hold their last values.
- Latency, accept edge = cycle 0:
  - store: ISSUE cycle 1, rsp_valid cycle 2.
  - fetch: ISSUE cycle 1, data sampled cycle 1+FETCH_LAT, rsp_valid cycle 2+FETCH_LAT.
  - misaligned/NOP: rsp_valid cycle 1.
- Throughput: next accept possible in the cycle after RESP. Back-to-back stores: one every 3 cycles.
- Reset mid-operation: the next edge forces the reset values. An in-flight fetch result is discarded and no rsp_valid is produced for it. RAM_STORE is never driven for more than one cycle.
- req_valid during non-IDLE states is ignored; the requester must hold it until accepted.

Decomposition:
- pkg_ram: reuse op_t, data_type_t, RAM_ADDRW, RAM_LONG_SIZE. Add these to pkg_ram:
  - typedef ram_init_state_t {IDLE, ISSUE, WAIT, RESP}
  - function ram_extend(data, type, signed)
  - function ram_aligned(addr, type)
- Sub-module: none required. The extension/alignment logic lives in the package functions so the future store/fetch paths can share it.

Test Plan:
- Reset: hold rst 2 cycles mid-fetch (during WAIT, FETCH_LAT=3) -> ram_op=NOP, req_ready=1, no rsp_valid, all outputs at reset values.
- Aligned STORE LONG, addr=0x00104, wdata=0xDEADBEEF -> cycle 1: ram_op=STORE, ram_addr=0x00104, ram_wdata=0xDEADBEEF; cycle 2: rsp_valid=1, rsp_err=0, rsp_rdata=0.
- STORE BYTE, wdata=0x123456A5 -> ram_wdata=0x000000A5, ram_type=RAM_BYTE.
- FETCH BYTE signed, addr=0x00003, RAM model returns 0x00000080:
  - FETCH_LAT=1 -> rsp_valid at cycle 3, rsp_rdata=0xFFFFFF80.
  - same fetch unsigned -> 0x00000080.
- FETCH WORD signed, RAM returns 0x0000ABCD, FETCH_LAT=2 -> rsp_rdata=0xFFFFABCD at cycle 4.
- Misaligned WORD at 0x00001 and LONG at 0x00006 -> ram_op stays NOP; rsp_valid at cycle 1, rsp_err=1, rsp_rdata=0.
- Back-to-back: req_valid held high for 3 stores -> accepts at cycles 0, 3, 6; exactly 3 one-cycle STOREs and 3 rsp_valid pulses.
